uart_ocram_loader: RTL
======================

UART_OCRAM_LOADER -- requirements
Module: uart_ocram_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 15, RAM word-address width.
REQ-002 SHALL have parameter IDLE_TIMEOUT, default 1024, the number of clk cycles without an accepted byte before a partial word is auto-flushed (minimum 2).
REQ-003 SHALL have these ports (name, direction, width, meaning):
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- rx_data  in  8  received UART byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  loader accepts a byte when rx_valid&rx_ready.
- flush  in  1  one-cycle pulse; write out the partially filled word.
- load_addr  in  1  one-cycle pulse; set the write pointer.
- start_addr  in  ADDR_W  pointer value for load_addr.
- address  out  ADDR_W  RAM word address.
- byteenable  out  4  RAM byte lanes.
- chipselect  out  1  RAM select.
- write  out  1  RAM write strobe.
- writedata  out  32  RAM write data.
- word_count  out  16  RAM writes issued; saturates at 16'hFFFF.
- wrapped  out  1  sticky flag; pointer has wrapped.
- busy  out  1  accumulator non-empty or a write is in progress.

Function
REQ-004 SHALL implement a two-state FSM: COLLECT and WRITE.
REQ-005 SHALL keep all outputs registered.
REQ-006 SHALL pack bytes little-endian: the k-th byte of a word (k=0..3) goes to writedata[8k+7:8k], byte lane k.
REQ-007 SHALL assert rx_ready in COLLECT and deassert it in WRITE.
REQ-008 SHALL, on the byte that fills lane 3, enter WRITE on the next cycle with chipselect=write=1, byteenable=4'b1111, and address=the write pointer.
REQ-009 SHALL hold WRITE for exactly one cycle, since the RAM has no waitrequest, then return to COLLECT.
REQ-010 SHALL keep chipselect and write low in COLLECT; address, byteenable and writedata are don't-care when write=0.
REQ-011 SHALL, when flush is high in COLLECT with 1-3 lanes filled, enter WRITE with byteenable set to exactly the filled lanes (for example 4'b0011 for 2 bytes).
REQ-012 SHALL treat flush as a no-op when the accumulator is empty.
REQ-013 SHALL treat flush in WRITE as a no-op.
REQ-014 SHALL handle a byte accepted in the same cycle as flush by including that byte in the flushed word; if that byte fills lane 3, exactly one full write results.
REQ-015 SHALL run an idle counter while the accumulator is non-empty in COLLECT, cleared on each accepted byte.
REQ-016 SHALL, when the idle counter reaches IDLE_TIMEOUT, behave exactly as a flush.
REQ-017 SHALL, after every write cycle, clear the accumulator to lane 0, increment the pointer modulo 2^ADDR_W, and increment word_count with saturation.
REQ-018 SHALL set wrapped when the pointer advances from 2^ADDR_W-1 to 0; wrapped stays set until reset.
REQ-019 SHALL honour load_addr only in COLLECT with an empty accumulator; otherwise load_addr is ignored.
REQ-020 SHALL, when load_addr is honoured and a byte is accepted in the same cycle, place that byte in lane 0 of the word at start_addr.
REQ-021 SHALL have latency of one cycle: byte accepted at cycle N completes a word -> write=1 at N+1, rx_ready=0 at N+1, rx_ready=1 at N+2.
REQ-022 SHALL sustain one word written per 5 cycles at most.
REQ-023 SHALL drive busy=1 whenever the accumulator is non-empty or the FSM is in WRITE.

Reset
REQ-024 SHALL, while reset is high, force: FSM=COLLECT, rx_ready=0, write=0, chipselect=0, byteenable=0, writedata=0, address=0, pointer=0, accumulator empty, idle counter=0, word_count=0, wrapped=0, busy=0.
REQ-025 SHALL drive rx_ready=1 on the first cycle after reset deasserts.
REQ-026 SHALL, if reset is asserted mid-word or in WRITE, discard the partial data and suppress any write in the following cycle.

Verification
REQ-027 Bytes 11,22,33,44 on consecutive cycles from reset -> one write, address=0, byteenable=F, writedata=44332211, word_count=1.
REQ-028 Bytes AA,BB then flush -> write with byteenable=3, writedata[15:0]=BBAA; next full word lands at address 1.
REQ-029 One byte 5A, then idle for IDLE_TIMEOUT cycles -> auto write with byteenable=1, data[7:0]=5A; flush with empty accumulator -> no write.
REQ-030 load_addr with start_addr=7FFF, then 8 bytes -> writes at 7FFF then 0000; wrapped=1 after the first write.
REQ-031 rx_valid held high continuously with bytes 00..0B -> 3 writes, each with rx_ready low for exactly one cycle; reset asserted after byte 0D -> no write, word_count=0.

Source files
------------

// File: rtl/uart_ocram_loader.sv
// Packs received UART bytes little-endian into 32-bit words and writes them to an
// on-chip RAM through a single-cycle write port (no waitrequest).
module uart_ocram_loader #(
  parameter int unsigned ADDR_W       = 15,
  parameter int unsigned IDLE_TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              flush,
  input  logic              load_addr,
  input  logic [ADDR_W-1:0] start_addr,
  output logic [ADDR_W-1:0] address,
  output logic [3:0]        byteenable,
  output logic              chipselect,
  output logic              write,
  output logic [31:0]       writedata,
  output logic [15:0]       word_count,
  output logic              wrapped,
  output logic              busy
);

  localparam int unsigned IDLE_W = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TIMEOUT - 1);

  typedef enum logic {ST_COLLECT = 1'b0, ST_WRITE = 1'b1} state_e;

  state_e              state_q, state_d;
  logic [31:0]         acc_q, acc_d;
  logic [2:0]          fill_q, fill_d;
  logic [IDLE_W-1:0]   idle_q, idle_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic                rx_ready_q, rx_ready_d;
  logic                wr_q, wr_d;
  logic [3:0]          be_q, be_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [15:0]         wcount_q, wcount_d;
  logic                wrapped_q, wrapped_d;
  logic                busy_q, busy_d;

  logic                accept, in_collect, load_ok, timeout, flush_req, go_write;
  logic [2:0]          fill_new;
  logic [31:0]         acc_new;
  logic [ADDR_W-1:0]   ptr_base;

  function automatic logic [3:0] lane_mask(input logic [2:0] n);
    case (n)
      3'd1:    lane_mask = 4'b0001;
      3'd2:    lane_mask = 4'b0011;
      3'd3:    lane_mask = 4'b0111;
      3'd4:    lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
  endfunction

  // rx_ready_q is only ever high in COLLECT, so accept implies COLLECT
  assign accept     = rx_valid & rx_ready_q;
  assign in_collect = (state_q == ST_COLLECT);
  assign load_ok    = in_collect & load_addr & (fill_q == 3'd0);
  assign fill_new   = fill_q + {2'b00, accept};
  assign timeout    = in_collect & (fill_q != 3'd0) & ~accept & (idle_q == IDLE_LAST);
  assign flush_req  = in_collect & (flush | timeout);
  assign go_write   = in_collect & ((fill_new == 3'd4) | (flush_req & (fill_new != 3'd0)));
  assign ptr_base   = load_ok ? start_addr : ptr_q;

  always_comb begin
    acc_new = acc_q;
    if (accept) acc_new[{fill_q[1:0], 3'b000} +: 8] = rx_data;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_COLLECT;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_COLLECT: if (go_write) state_d = ST_WRITE;
      ST_WRITE:   state_d = ST_COLLECT;
      default:    state_d = ST_COLLECT;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    acc_d      = acc_q;
    fill_d     = fill_q;
    idle_d     = idle_q;
    ptr_d      = ptr_q;
    wr_d       = 1'b0;
    be_d       = be_q;
    wdata_d    = wdata_q;
    addr_d     = addr_q;
    wcount_d   = wcount_q;
    wrapped_d  = wrapped_q;
    rx_ready_d = (state_d == ST_COLLECT);
    if (in_collect) begin
      acc_d  = acc_new;
      fill_d = fill_new;
      ptr_d  = ptr_base;
      if (accept)                 idle_d = '0;
      else if (fill_q != 3'd0)    idle_d = idle_q + IDLE_W'(1);
      if (go_write) begin
        wr_d    = 1'b1;
        be_d    = lane_mask(fill_new);
        wdata_d = acc_new;
        addr_d  = ptr_base;
      end
    end else begin
      acc_d  = '0;
      fill_d = 3'd0;
      idle_d = '0;
      ptr_d  = ptr_q + ADDR_W'(1);
      if (ptr_q == '1)          wrapped_d = 1'b1;
      if (wcount_q != 16'hFFFF) wcount_d  = wcount_q + 16'd1;
    end
    busy_d = (state_d == ST_WRITE) | (fill_d != 3'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q      <= '0;
      fill_q     <= 3'd0;
      idle_q     <= '0;
      ptr_q      <= '0;
      rx_ready_q <= 1'b0;
      wr_q       <= 1'b0;
      be_q       <= 4'b0000;
      wdata_q    <= '0;
      addr_q     <= '0;
      wcount_q   <= 16'd0;
      wrapped_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      fill_q     <= fill_d;
      idle_q     <= idle_d;
      ptr_q      <= ptr_d;
      rx_ready_q <= rx_ready_d;
      wr_q       <= wr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      addr_q     <= addr_d;
      wcount_q   <= wcount_d;
      wrapped_q  <= wrapped_d;
      busy_q     <= busy_d;
    end
  end

  assign rx_ready   = rx_ready_q;
  assign write      = wr_q;
  assign chipselect = wr_q;
  assign byteenable = be_q;
  assign writedata  = wdata_q;
  assign address    = addr_q;
  assign word_count = wcount_q;
  assign wrapped    = wrapped_q;
  assign busy       = busy_q;

endmodule
